// File: rtl/vga_controller.sv
// 640x480 @ 60 Hz VGA timing generator and pixel output stage.
// x/y come straight from the counters; sync and colour are registered one clock later.
module vga_controller #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter bit          SYNC_POL  = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    output logic [9:0] x,
    output logic [9:0] y,
    input  logic [3:0] red,
    input  logic [3:0] green,
    input  logic [3:0] blue,
    output logic       hsync,
    output logic       vsync,
    output logic [3:0] vga_red,
    output logic [3:0] vga_green,
    output logic [3:0] vga_blue
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // Sized copies of the timing constants so every compare is 10 bits wide.
    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
    localparam logic [9:0] H_SYNC_BEG = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] H_SYNC_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] V_SYNC_BEG = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] V_SYNC_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic active;
    logic in_hwin;
    logic in_vwin;

    always_ff @(posedge clk) begin
        if (reset) begin
            x <= '0;
            y <= '0;
        end else if (x == H_LAST) begin
            x <= '0;
            y <= (y == V_LAST) ? 10'd0 : y + 10'd1;
        end else begin
            x <= x + 10'd1;
        end
    end

    always_comb begin
        active  = (x < H_VIS) && (y < V_VIS);
        in_hwin = (x >= H_SYNC_BEG) && (x < H_SYNC_END);
        in_vwin = (y >= V_SYNC_BEG) && (y < V_SYNC_END);
    end

    // Colour is sampled on the same edge as the x/y it was computed from,
    // so sync and colour leave together one clock behind the counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            hsync     <= ~SYNC_POL;
            vsync     <= ~SYNC_POL;
            vga_red   <= 4'h0;
            vga_green <= 4'h0;
            vga_blue  <= 4'h0;
        end else begin
            hsync     <= in_hwin ? SYNC_POL : ~SYNC_POL;
            vsync     <= in_vwin ? SYNC_POL : ~SYNC_POL;
            vga_red   <= active ? red   : 4'h0;
            vga_green <= active ? green : 4'h0;
            vga_blue  <= active ? blue  : 4'h0;
        end
    end

endmodule

// File: tb/tb_vga_controller.sv
// Directed bench for vga_controller: full-size instance for horizontal timing,
// latency and mid-frame reset; a short-frame instance for vertical timing.
module tb_vga_controller;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #20 clk = ~clk;

    logic reset;
    logic reset_s;

    // ---------------- DUT wiring ----------------
    logic [9:0] x, y;
    logic [3:0] red, green, blue;
    logic       hsync, vsync;
    logic [3:0] vga_red, vga_green, vga_blue;
    logic       mode;

    // Renderer: mode 0 = solid white, mode 1 = pattern derived from x/y.
    assign red   = mode ? x[3:0]  : 4'hF;
    assign green = mode ? ~x[3:0] : 4'hF;
    assign blue  = mode ? y[3:0]  : 4'hF;

    vga_controller dut (
        .clk(clk), .reset(reset), .x(x), .y(y),
        .red(red), .green(green), .blue(blue),
        .hsync(hsync), .vsync(vsync),
        .vga_red(vga_red), .vga_green(vga_green), .vga_blue(vga_blue)
    );

    // Short frame: 6 visible + 2 front + 2 sync + 3 back = 13 lines.
    logic [9:0] xs, ys;
    logic       hsync_s, vsync_s;
    logic [3:0] vga_red_s, vga_green_s, vga_blue_s;
    logic [3:0] white;
    assign white = 4'hF;

    vga_controller #(.V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)) dut_s (
        .clk(clk), .reset(reset_s), .x(xs), .y(ys),
        .red(white), .green(white), .blue(white),
        .hsync(hsync_s), .vsync(vsync_s),
        .vga_red(vga_red_s), .vga_green(vga_green_s), .vga_blue(vga_blue_s)
    );

    // ---------------- checking ----------------
    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_x"},     x, 0);
        check({tag, "_y"},     y, 0);
        check({tag, "_hsync"}, hsync, 1);
        check({tag, "_vsync"}, vsync, 1);
        check({tag, "_red"},   vga_red, 0);
        check({tag, "_green"}, vga_green, 0);
        check({tag, "_blue"},  vga_blue, 0);
    endtask

    // ---------------- scoreboard ----------------
    logic [11:0] exp_q[$];
    int          sb_err = 0;
    int          sb_n   = 0;

    logic small_go   = 1'b0;
    logic small_done = 1'b0;

    // ---------------- short-frame monitor ----------------
    initial begin
        int vs_cnt, vs_first, vs_last, hs_cnt, f_cnt, f_blank, max_x, max_y;
        int k, xi, yi, pos;
        vs_cnt = 0; vs_first = -1; vs_last = -1; hs_cnt = 0;
        f_cnt = 0; f_blank = 0; max_x = 0; max_y = 0;
        wait (small_go);
        for (int i = 0; i < 10400; i++) begin
            tick(1);
            k   = i + 1;
            xi  = k % 800;
            yi  = (k / 800) % 13;
            pos = yi * 800 + xi;
            if (int'(xs) > max_x) max_x = int'(xs);
            if (int'(ys) > max_y) max_y = int'(ys);
            if (vsync_s == 1'b0) begin
                vs_cnt++;
                if (vs_first < 0) vs_first = pos;
                vs_last = pos;
            end
            if (hsync_s == 1'b0) hs_cnt++;
            if (vga_red_s == 4'hF && vga_green_s == 4'hF && vga_blue_s == 4'hF) begin
                f_cnt++;
                // Output reflects previous position; lines 6..12 are blank.
                if ((k - 1) / 800 >= 6) f_blank++;
            end
        end
        check("vframe_wrap_x", xs, 0);
        check("vframe_wrap_y", ys, 0);
        check("vsync_low_count", vs_cnt, 1600);
        check("vsync_first_pos", vs_first, 8 * 800 + 1);
        check("vsync_last_pos", vs_last, 10 * 800);
        check("hsync_low_per_frame", hs_cnt, 96 * 13);
        check("white_per_frame", f_cnt, 640 * 6);
        check("white_in_blank_lines", f_blank, 0);
        check("max_x_seen", max_x, 799);
        check("max_y_seen", max_y, 12);
        small_done = 1'b1;
    end

    // ---------------- main sequence ----------------
    initial begin
        int hs_cnt, hs_first, hs_last, vs_cnt, f_cnt, f_first, xi, k;
        logic [11:0] exp_v, got_v;
        logic [3:0]  kn;

        reset = 1'b1; reset_s = 1'b1; mode = 1'b0;
        tick(1);
        check_reset_state("reset");
        reset = 1'b0; reset_s = 1'b0; small_go = 1'b1;

        tick(37);
        check("count37_x", x, 37);
        check("count37_y", y, 0);
        tick(762);
        check("line_end_x", x, 799);
        check("line_end_y", y, 0);
        tick(1);
        check("hwrap_x", x, 0);
        check("hwrap_y", y, 1);

        // Line 1: hsync window and white span.
        hs_cnt = 0; hs_first = -1; hs_last = -1; vs_cnt = 0; f_cnt = 0; f_first = -1;
        for (int i = 0; i < 800; i++) begin
            tick(1);
            xi = (i + 1) % 800;
            if (hsync == 1'b0) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = xi;
                hs_last = xi;
            end
            if (vsync == 1'b0) vs_cnt++;
            if (vga_red == 4'hF && vga_green == 4'hF && vga_blue == 4'hF) begin
                f_cnt++;
                if (f_first < 0) f_first = xi;
            end
        end
        check("hsync_low_count", hs_cnt, 96);
        check("hsync_first_x", hs_first, 657);
        check("hsync_last_x", hs_last, 752);
        check("vsync_line1", vs_cnt, 0);
        check("white_count_line", f_cnt, 640);
        check("white_first_x", f_first, 1);
        check("line2_y", y, 2);

        // Line 2: one-clock colour latency through the expected queue.
        mode = 1'b1;
        for (int i = 0; i < 800; i++) begin
            k  = i;
            kn = k[3:0];
            exp_v = (k < 640) ? {kn, ~kn, 4'd2} : 12'h000;
            exp_q.push_back(exp_v);
            tick(1);
            got_v = {vga_red, vga_green, vga_blue};
            if (got_v !== exp_q.pop_front()) sb_err++;
            if (int'(x) != (k + 1) % 800) sb_err++;
            sb_n++;
        end
        check("latency_scoreboard", sb_err, 0);
        check("latency_samples", sb_n, 800);

        tick(101);
        check("lat_x", x, 101);
        check("lat_red", vga_red, 4);
        check("lat_green", vga_green, 11);
        check("lat_blue", vga_blue, 3);

        // Mid-frame reset at (300,20) with a non-zero colour in flight.
        tick((20 - 3) * 800 + (300 - 101));
        check("pre_reset_x", x, 300);
        check("pre_reset_y", y, 20);
        reset = 1'b1;
        tick(1);
        check_reset_state("midreset");
        reset = 1'b0;
        tick(5);
        check("resume_x", x, 5);
        check("resume_y", y, 0);
        check("resume_red", vga_red, 4);

        // Reset inside the hsync pulse must end the pulse immediately.
        tick(695);
        check("in_hwin_x", x, 700);
        check("in_hwin_hsync", hsync, 0);
        reset = 1'b1;
        tick(1);
        check("hwin_reset_hsync", hsync, 1);
        check("hwin_reset_x", x, 0);
        reset = 1'b0;
        tick(1);
        check("hwin_after_x", x, 1);
        check("hwin_after_hsync", hsync, 1);

        for (int i = 0; i < 20000 && !small_done; i++) tick(1);
        check("small_frame_done", small_done, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
